main_controller: RTL and testbench

MAIN_CONTROLLER -- requirements
Module: main_controller

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/main_controller_if.sv | 36 +++
 rtl/alu_decoder.sv | 43 ++++
 rtl/main_controller.sv | 180 ++++++++++++++++++
 tb/tb_main_controller.sv | 385 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle controller: opcodes, funct3 codes,
// datapath select encodings, ALU control codes and the controller state type.
package cpu_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [2:0] A_OLD_PC = 3'd0;
    localparam logic [2:0] A_PC     = 3'd1;
    localparam logic [2:0] A_REG    = 3'd2;

    localparam logic [2:0] B_REG  = 3'd0;
    localparam logic [2:0] B_IMM  = 3'd1;
    localparam logic [2:0] B_FOUR = 3'd2;

    localparam logic [2:0] OUT_ALU_REG = 3'd0;
    localparam logic [2:0] OUT_ALU     = 3'd1;
    localparam logic [2:0] OUT_DATA    = 3'd2;

    localparam logic ADR_PC  = 1'b0;
    localparam logic ADR_BUS = 1'b1;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_LUI, S_AUIPC, S_HALT, S_TRAP
    } state_t;

endpackage

// File: rtl/main_controller_if.sv
// Instruction fields in, datapath strobes and selects out; the controller
// takes the master side, the datapath (or a bench) the slave side.
interface main_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero_flag;

    logic       adr_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       output_en;
    logic [2:0] out_mux_sel;
    logic [2:0] imm_sel;
    logic [2:0] alu_src_a_sel;
    logic [2:0] alu_src_b_sel;
    logic [3:0] alu_ctrl;
    logic       halted;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7, zero_flag,
        output adr_src, pc_write, ir_write, mem_write, reg_write, output_en,
               out_mux_sel, imm_sel, alu_src_a_sel, alu_src_b_sel, alu_ctrl,
               halted, illegal
    );

    modport slave (
        output opcode, funct3, funct7, zero_flag,
        input  adr_src, pc_write, ir_write, mem_write, reg_write, output_en,
               out_mux_sel, imm_sel, alu_src_a_sel, alu_src_b_sel, alu_ctrl,
               halted, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU-control decode from the instruction fields. Branch
// funct3 010/011 are not real branches and fall back to ADD.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl
);

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (opcode)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000:  alu_ctrl = (opcode == OP_R && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            OP_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   alu_ctrl = ALU_SUB;
                    2'b10:   alu_ctrl = ALU_SLT;
                    2'b11:   alu_ctrl = ALU_SLTU;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            OP_LUI:  alu_ctrl = ALU_PASSB;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/main_controller.sv
// Moore multicycle controller: state register plus a combinational block that
// produces next state and all datapath strobes/selects from the current state.
module main_controller
    import cpu_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    main_controller_if.master bus
);

    state_t     state;
    state_t     next_state;
    logic [3:0] decoded_alu;
    logic       branch_taken;

    logic       adr_src;
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       output_en;
    logic [2:0] out_mux_sel;
    logic [2:0] imm_sel;
    logic [2:0] a_sel;
    logic [2:0] b_sel;
    logic [3:0] alu_ctrl;
    logic       halted;
    logic       illegal;

    alu_decoder u_alu_decoder (
        .opcode   (bus.opcode),
        .funct3   (bus.funct3),
        .funct7   (bus.funct7),
        .alu_ctrl (decoded_alu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    // Equality branches and the ">=" forms take the branch on a zero ALU result.
    always_comb begin
        branch_taken = 1'b0;
        case (bus.funct3)
            F3_BEQ, F3_BGE, F3_BGEU: branch_taken = bus.zero_flag;
            F3_BNE, F3_BLT, F3_BLTU: branch_taken = ~bus.zero_flag;
            default:                 branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state  = state;
        adr_src     = ADR_PC;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        output_en   = 1'b0;
        out_mux_sel = OUT_ALU_REG;
        imm_sel     = IMM_I;
        a_sel       = A_OLD_PC;
        b_sel       = B_REG;
        alu_ctrl    = ALU_ADD;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write    = 1'b1;
                pc_write    = 1'b1;
                a_sel       = A_PC;
                b_sel       = B_FOUR;
                out_mux_sel = OUT_ALU;
                next_state  = S_DECODE;
            end
            S_DECODE: begin
                b_sel   = B_IMM;
                imm_sel = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_R:              next_state = S_EXECR;
                    OP_I:              next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI:            next_state = S_LUI;
                    OP_AUIPC:          next_state = S_AUIPC;
                    OP_SYSTEM:         next_state = S_HALT;
                    default:           next_state = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                a_sel      = A_REG;
                b_sel      = B_IMM;
                imm_sel    = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
                next_state = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = ADR_BUS;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                out_mux_sel = OUT_DATA;
                reg_write   = 1'b1;
                output_en   = 1'b1;
                next_state  = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = ADR_BUS;
                mem_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_EXECR: begin
                a_sel      = A_REG;
                alu_ctrl   = decoded_alu;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                a_sel      = A_REG;
                b_sel      = B_IMM;
                alu_ctrl   = decoded_alu;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                output_en  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                a_sel      = A_REG;
                alu_ctrl   = decoded_alu;
                pc_write   = branch_taken;
                next_state = S_FETCH;
            end
            S_JAL: begin
                b_sel      = B_FOUR;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end
            // JALR only computes the target here and reuses JAL for link/redirect.
            S_JALR: begin
                a_sel      = A_REG;
                b_sel      = B_IMM;
                next_state = S_JAL;
            end
            S_LUI: begin
                b_sel      = B_IMM;
                imm_sel    = IMM_U;
                alu_ctrl   = decoded_alu;
                next_state = S_ALUWB;
            end
            S_AUIPC: begin
                b_sel      = B_IMM;
                imm_sel    = IMM_U;
                next_state = S_ALUWB;
            end
            S_HALT:  halted  = 1'b1;
            S_TRAP:  illegal = 1'b1;
            default: next_state = S_FETCH;
        endcase
    end

    // Write strobes are gated by reset so nothing is committed while it is held.
    assign bus.adr_src       = adr_src;
    assign bus.pc_write      = pc_write & ~rst;
    assign bus.ir_write      = ir_write & ~rst;
    assign bus.mem_write     = mem_write & ~rst;
    assign bus.reg_write     = reg_write & ~rst;
    assign bus.output_en     = output_en & ~rst;
    assign bus.out_mux_sel   = out_mux_sel;
    assign bus.imm_sel       = imm_sel;
    assign bus.alu_src_a_sel = a_sel;
    assign bus.alu_src_b_sel = b_sel;
    assign bus.alu_ctrl      = alu_ctrl;
    assign bus.halted        = halted;
    assign bus.illegal       = illegal;

endmodule

// File: tb/tb_main_controller.sv
// Bench for main_controller: each instruction is expanded into its expected
// per-cycle control vectors and compared against two DUTs (trap on / trap off).
module tb_main_controller;

    typedef struct packed {
        logic       adr_src;
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       output_en;
        logic [2:0] out_mux;
        logic [2:0] imm;
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] alu;
        logic       halted;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       zf;
    } instr_t;

    logic       clk = 1'b0;
    logic [1:0] rst_req = 2'b11;
    logic [1:0] rst_next = 2'b11;
    logic [6:0] op_in [2];
    logic [2:0] f3_in [2];
    logic [6:0] f7_in [2];
    logic       zf_in [2];

    ctl_t  act [2];
    ctl_t  exp_cur [2];
    ctl_t  mask_cur [2];
    string tag_cur [2];
    ctl_t  seq_buf [2][8];
    string tag_buf [2][8];
    int    seq_len [2];
    int    seq_pos [2];
    bit    term [2];
    bit    started = 1'b0;
    ctl_t  rst_mask;

    instr_t dir_q0 [$];
    instr_t dir_q1 [$];

    int checks = 0;
    int errors = 0;

    main_controller_if bus0 ();
    main_controller_if bus1 ();

    main_controller #(.ILLEGAL_TRAP(1)) dut0 (.clk(clk), .rst(rst_req[0]), .bus(bus0));
    main_controller #(.ILLEGAL_TRAP(0)) dut1 (.clk(clk), .rst(rst_req[1]), .bus(bus1));

    always #5 clk = ~clk;

    assign bus0.opcode = op_in[0];
    assign bus0.funct3 = f3_in[0];
    assign bus0.funct7 = f7_in[0];
    assign bus0.zero_flag = zf_in[0];
    assign bus1.opcode = op_in[1];
    assign bus1.funct3 = f3_in[1];
    assign bus1.funct7 = f7_in[1];
    assign bus1.zero_flag = zf_in[1];

    assign act[0] = {bus0.adr_src, bus0.pc_write, bus0.ir_write, bus0.mem_write, bus0.reg_write,
                     bus0.output_en, bus0.out_mux_sel, bus0.imm_sel, bus0.alu_src_a_sel,
                     bus0.alu_src_b_sel, bus0.alu_ctrl, bus0.halted, bus0.illegal};
    assign act[1] = {bus1.adr_src, bus1.pc_write, bus1.ir_write, bus1.mem_write, bus1.reg_write,
                     bus1.output_en, bus1.out_mux_sel, bus1.imm_sel, bus1.alu_src_a_sel,
                     bus1.alu_src_b_sel, bus1.alu_ctrl, bus1.halted, bus1.illegal};

    function automatic instr_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic zf);
        instr_t i;
        i.op = op; i.f3 = f3; i.f7 = f7; i.zf = zf;
        return i;
    endfunction

    function automatic instr_t from_word(logic [31:0] w, logic zf);
        return mk(w[6:0], w[14:12], w[31:25], zf);
    endfunction

    function automatic bit is_legal(logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b0010011 ||
               op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111 || op == 7'b0110111 ||
               op == 7'b0010111 || op == 7'b1110011;
    endfunction

    // Arithmetic op table indexed by funct3; bit 5 of funct7 selects SUB/SRA variants.
    function automatic logic [3:0] arith_alu(logic [2:0] f3, logic b5, bit reg_form);
        logic [3:0] tab [8];
        tab = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
        if (f3 == 3'd0 && b5 && reg_form) return 4'd1;
        if (f3 == 3'd5 && b5) return 4'd7;
        return tab[f3];
    endfunction

    function automatic logic [3:0] branch_alu(logic [2:0] f3);
        case (f3)
            3'd0, 3'd1: return 4'd1;
            3'd4, 3'd5: return 4'd8;
            3'd6, 3'd7: return 4'd9;
            default:    return 4'd0;
        endcase
    endfunction

    function automatic logic branch_taken(logic [2:0] f3, logic zf);
        case (f3)
            3'd0, 3'd5, 3'd7: return zf;
            3'd1, 3'd4, 3'd6: return !zf;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        int cat;
        logic [6:0] op;
        cat = $urandom_range(0, 99);
        if (cat < 15)      op = 7'b0110011;
        else if (cat < 30) op = 7'b0010011;
        else if (cat < 42) op = 7'b0000011;
        else if (cat < 52) op = 7'b0100011;
        else if (cat < 67) op = 7'b1100011;
        else if (cat < 73) op = 7'b1101111;
        else if (cat < 79) op = 7'b1100111;
        else if (cat < 85) op = 7'b0110111;
        else if (cat < 91) op = 7'b0010111;
        else if (cat < 95) op = 7'b1110011;
        else begin
            op = 7'($urandom_range(0, 127));
            while (is_legal(op)) op = 7'($urandom_range(0, 127));
        end
        return mk(op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    endfunction

    function automatic instr_t next_instr(int d);
        if (d == 0 && dir_q0.size() > 0) return dir_q0.pop_front();
        if (d == 1 && dir_q1.size() > 0) return dir_q1.pop_front();
        return rand_instr();
    endfunction

    // Expands one instruction into the control vector of every cycle it occupies.
    function automatic void gen(input int d, input instr_t i, input bit trap_en,
                                output int n, output bit tm);
        ctl_t c;
        ctl_t wb;
        for (int k = 0; k < 8; k++) begin seq_buf[d][k] = '0; tag_buf[d][k] = ""; end
        tm = 1'b0;
        wb = '0; wb.reg_write = 1'b1; wb.output_en = 1'b1;
        c = '0; c.ir_write = 1'b1; c.pc_write = 1'b1; c.a = 3'd1; c.b = 3'd2; c.out_mux = 3'd1;
        seq_buf[d][0] = c; tag_buf[d][0] = "FETCH";
        c = '0; c.b = 3'd1; c.imm = (i.op == 7'b1101111) ? 3'd3 : 3'd2;
        seq_buf[d][1] = c; tag_buf[d][1] = "DECODE";
        n = 2;
        case (i.op)
            7'b0000011, 7'b0100011: begin
                c = '0; c.a = 3'd2; c.b = 3'd1; c.imm = (i.op == 7'b0100011) ? 3'd1 : 3'd0;
                seq_buf[d][2] = c; tag_buf[d][2] = "MEMADR";
                c = '0; c.adr_src = 1'b1; c.mem_write = (i.op == 7'b0100011);
                seq_buf[d][3] = c; tag_buf[d][3] = (i.op == 7'b0100011) ? "MEMWRITE" : "MEMREAD";
                n = 4;
                if (i.op == 7'b0000011) begin
                    c = wb; c.out_mux = 3'd2;
                    seq_buf[d][4] = c; tag_buf[d][4] = "MEMWB"; n = 5;
                end
            end
            7'b0110011, 7'b0010011: begin
                c = '0; c.a = 3'd2; c.b = (i.op == 7'b0010011) ? 3'd1 : 3'd0;
                c.alu = arith_alu(i.f3, i.f7[5], i.op == 7'b0110011);
                seq_buf[d][2] = c; tag_buf[d][2] = "EXEC";
                seq_buf[d][3] = wb; tag_buf[d][3] = "ALUWB"; n = 4;
            end
            7'b1100011: begin
                c = '0; c.a = 3'd2; c.alu = branch_alu(i.f3); c.pc_write = branch_taken(i.f3, i.zf);
                seq_buf[d][2] = c; tag_buf[d][2] = "BRANCH"; n = 3;
            end
            7'b1101111, 7'b1100111: begin
                if (i.op == 7'b1100111) begin
                    c = '0; c.a = 3'd2; c.b = 3'd1;
                    seq_buf[d][n] = c; tag_buf[d][n] = "JALR"; n++;
                end
                c = '0; c.b = 3'd2; c.pc_write = 1'b1;
                seq_buf[d][n] = c; tag_buf[d][n] = "JAL"; n++;
                seq_buf[d][n] = wb; tag_buf[d][n] = "ALUWB"; n++;
            end
            7'b0110111, 7'b0010111: begin
                c = '0; c.b = 3'd1; c.imm = 3'd4; c.alu = (i.op == 7'b0110111) ? 4'd10 : 4'd0;
                seq_buf[d][2] = c; tag_buf[d][2] = "UPPER";
                seq_buf[d][3] = wb; tag_buf[d][3] = "ALUWB"; n = 4;
            end
            7'b1110011: begin
                c = '0; c.halted = 1'b1;
                seq_buf[d][2] = c; tag_buf[d][2] = "HALT"; n = 3; tm = 1'b1;
            end
            default: begin
                if (trap_en) begin
                    c = '0; c.illegal = 1'b1;
                    seq_buf[d][2] = c; tag_buf[d][2] = "TRAP"; n = 3; tm = 1'b1;
                end
            end
        endcase
    endfunction

    task automatic checkValue(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL model %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic checkOutput(input int d, input ctl_t got, input ctl_t want,
                               input ctl_t mask, input string tag);
        checks++;
        if ((got & mask) !== (want & mask)) begin
            errors++;
            $display("[TB] FAIL dut%0d %s @%0t: got %h expected %h (mask %h)",
                     d, tag, $time, got & mask, want & mask, mask);
        end
    endtask

    // Hand-computed anchors for the expansion model.
    task automatic pinModel();
        int n; bit tm;
        gen(0, from_word(32'h002081B3, 1'b0), 1'b1, n, tm);
        checkValue("add length", n, 4);
        checkValue("add EXECR alu", int'(seq_buf[0][2].alu), 0);
        checkValue("add EXECR reg_write", int'(seq_buf[0][2].reg_write), 0);
        checkValue("add ALUWB reg_write", int'(seq_buf[0][3].reg_write), 1);
        gen(0, mk(7'b0110011, 3'd0, 7'h20, 1'b0), 1'b1, n, tm);
        checkValue("sub alu", int'(seq_buf[0][2].alu), 1);
        gen(0, mk(7'b0010011, 3'd0, 7'h20, 1'b0), 1'b1, n, tm);
        checkValue("addi alu", int'(seq_buf[0][2].alu), 0);
        gen(0, mk(7'b0010011, 3'd5, 7'h20, 1'b0), 1'b1, n, tm);
        checkValue("srai alu", int'(seq_buf[0][2].alu), 7);
        gen(0, mk(7'b0000011, 3'd2, 7'h00, 1'b0), 1'b1, n, tm);
        checkValue("lw length", n, 5);
        checkValue("lw MEMREAD adr_src", int'(seq_buf[0][3].adr_src), 1);
        checkValue("lw MEMWB out_mux", int'(seq_buf[0][4].out_mux), 2);
        gen(0, mk(7'b1100011, 3'd1, 7'h00, 1'b0), 1'b1, n, tm);
        checkValue("bne zf0 pc_write", int'(seq_buf[0][2].pc_write), 1);
        checkValue("branch length", n, 3);
        gen(0, mk(7'b1100011, 3'd1, 7'h00, 1'b1), 1'b1, n, tm);
        checkValue("bne zf1 pc_write", int'(seq_buf[0][2].pc_write), 0);
        gen(0, mk(7'b1111111, 3'd0, 7'h00, 1'b0), 1'b1, n, tm);
        checkValue("trap illegal", int'(seq_buf[0][2].illegal), 1);
        gen(0, mk(7'b1111111, 3'd0, 7'h00, 1'b0), 1'b0, n, tm);
        checkValue("no-trap length", n, 2);
    endtask

    task automatic applyStimulus();
        instr_t ins;
        int n;
        bit tm;
        @(posedge clk);
        #1;
        rst_req = rst_next;
        for (int d = 0; d < 2; d++) begin
            if (rst_req[d]) begin
                seq_len[d] = 0; seq_pos[d] = 0; term[d] = 1'b0;
                exp_cur[d] = '0; mask_cur[d] = rst_mask; tag_cur[d] = "reset";
            end else begin
                if (seq_pos[d] >= seq_len[d] && !term[d]) begin
                    ins = next_instr(d);
                    op_in[d] = ins.op; f3_in[d] = ins.f3; f7_in[d] = ins.f7; zf_in[d] = ins.zf;
                    gen(d, ins, d == 0, n, tm);
                    seq_len[d] = n; seq_pos[d] = 0; term[d] = tm;
                end
                if (seq_pos[d] < seq_len[d]) begin
                    exp_cur[d] = seq_buf[d][seq_pos[d]];
                    tag_cur[d] = tag_buf[d][seq_pos[d]];
                    seq_pos[d]++;
                end else begin
                    exp_cur[d] = seq_buf[d][seq_len[d] - 1];
                    tag_cur[d] = tag_buf[d][seq_len[d] - 1];
                end
                mask_cur[d] = '1;
            end
        end
        started = 1'b1;
    endtask

    // Runs random instructions on one DUT; halts/traps are left by a reset pulse.
    task automatic randomPhase(input int d, input int cycles);
        int hold = 0;
        for (int c = 0; c < cycles; c++) begin
            rst_next[d] = 1'b0;
            if (term[d] && seq_pos[d] >= seq_len[d]) begin
                hold++;
                if (hold >= 3 && $urandom_range(0, 3) == 0) begin
                    rst_next[d] = 1'b1;
                    hold = 0;
                end
            end else if ($urandom_range(0, 79) == 0) begin
                rst_next[d] = 1'b1;
            end
            applyStimulus();
        end
        rst_next[d] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) checkOutput(d, act[d], exp_cur[d], mask_cur[d], tag_cur[d]);
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            op_in[d] = '0; f3_in[d] = '0; f7_in[d] = '0; zf_in[d] = 1'b0;
            seq_len[d] = 0; seq_pos[d] = 0; term[d] = 1'b0;
            exp_cur[d] = '0; mask_cur[d] = '0; tag_cur[d] = "";
        end
        rst_mask = '0;
        rst_mask.pc_write = 1'b1; rst_mask.ir_write = 1'b1; rst_mask.mem_write = 1'b1;
        rst_mask.reg_write = 1'b1; rst_mask.output_en = 1'b1;
        rst_mask.halted = 1'b1; rst_mask.illegal = 1'b1;

        pinModel();

        rst_next = 2'b11;
        repeat (2) applyStimulus();

        $display("[TB] directed add/lw/bne on trap-enabled controller");
        rst_next = 2'b10;
        dir_q0.push_back(from_word(32'h002081B3, 1'b0));
        dir_q0.push_back(mk(7'b0000011, 3'd2, 7'h00, 1'b0));
        dir_q0.push_back(mk(7'b1100011, 3'd1, 7'h00, 1'b0));
        dir_q0.push_back(mk(7'b1100011, 3'd1, 7'h00, 1'b1));
        repeat (15) applyStimulus();

        $display("[TB] reset pulse during MEMWRITE");
        dir_q0.push_back(mk(7'b0100011, 3'd2, 7'h00, 1'b0));
        repeat (3) applyStimulus();
        rst_next[0] = 1'b1;
        applyStimulus();
        rst_next[0] = 1'b0;

        dir_q0.push_back(mk(7'b0100011, 3'd2, 7'h00, 1'b0));
        dir_q0.push_back(mk(7'b0110011, 3'd0, 7'h20, 1'b0));
        dir_q0.push_back(mk(7'b0010011, 3'd5, 7'h20, 1'b0));
        dir_q0.push_back(mk(7'b1110011, 3'd0, 7'h00, 1'b0));
        repeat (21) applyStimulus();
        rst_next[0] = 1'b1;
        applyStimulus();
        rst_next[0] = 1'b0;

        $display("[TB] illegal opcode held in TRAP");
        dir_q0.push_back(mk(7'b1111111, 3'd0, 7'h00, 1'b0));
        repeat (14) applyStimulus();
        rst_next[0] = 1'b1;
        applyStimulus();

        $display("[TB] random instruction stream, trap enabled");
        randomPhase(0, 600);

        $display("[TB] illegal opcode with trap disabled");
        rst_next = 2'b11;
        applyStimulus();
        rst_next = 2'b00;
        dir_q0.push_back(mk(7'b1111111, 3'd0, 7'h00, 1'b0));
        dir_q1.push_back(mk(7'b1111111, 3'd0, 7'h00, 1'b0));
        dir_q1.push_back(from_word(32'h002081B3, 1'b0));
        dir_q1.push_back(mk(7'b0000000, 3'd0, 7'h00, 1'b0));
        dir_q1.push_back(mk(7'b0000011, 3'd2, 7'h00, 1'b0));
        dir_q1.push_back(mk(7'b1100011, 3'd1, 7'h00, 1'b1));
        repeat (16) applyStimulus();

        $display("[TB] random instruction stream, trap disabled");
        rst_next = 2'b01;
        randomPhase(1, 300);

        rst_next = 2'b11;
        applyStimulus();
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
